boot_imem: RTL and testbench

//  Writable instruction memory with streaming program loader; successor to the fixed-content ROM.

---
 rtl/boot_imem_pkg.sv | 15 +
 rtl/boot_imem_if.sv | 45 ++++
 rtl/boot_imem_array.sv | 31 +++
 rtl/boot_imem.sv | 113 +++++++++++
 tb/tb_boot_imem.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/boot_imem_pkg.sv
// Shared types and constants for the boot instruction memory.
//   state_e        : loader FSM state encoding
//   NOP_WORD_DEFAULT : instruction served to the core whenever it is not running
package boot_imem_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StRun   = 2'd2,
    StError = 2'd3
  } state_e;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/boot_imem_if.sv
// Bus bundle between host/core side (master) and boot_imem (slave).
//   load_start, ld_valid, ld_data, ld_last : host program stream
//   ld_ready                               : loader accepts a word this cycle
//   iaddr / idata                          : core fetch byte address / instruction
//   core_reset_n                           : 0 holds the core in reset
//   load_done, load_error, word_count      : loader status
// Optional (BOOT_IMEM_CHECKSUM_EN): ld_csum expected sum, csum_ok result.
interface boot_imem_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  load_start;
  logic                  ld_valid;
  logic                  ld_ready;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_last;
  logic                  core_reset_n;
  logic [ADDR_WIDTH-1:0] iaddr;
  logic [DATA_WIDTH-1:0] idata;
  logic                  load_done;
  logic                  load_error;
  logic [ADDR_WIDTH-2:0] word_count;
`ifdef BOOT_IMEM_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] ld_csum;
  logic                  csum_ok;

  modport master (
    output load_start, ld_valid, ld_data, ld_last, iaddr, ld_csum,
    input  ld_ready, core_reset_n, idata, load_done, load_error, word_count, csum_ok
  );
  modport slave (
    input  load_start, ld_valid, ld_data, ld_last, iaddr, ld_csum,
    output ld_ready, core_reset_n, idata, load_done, load_error, word_count, csum_ok
  );
`else
  modport master (
    output load_start, ld_valid, ld_data, ld_last, iaddr,
    input  ld_ready, core_reset_n, idata, load_done, load_error, word_count
  );
  modport slave (
    input  load_start, ld_valid, ld_data, ld_last, iaddr,
    output ld_ready, core_reset_n, idata, load_done, load_error, word_count
  );
`endif
endinterface

// File: rtl/boot_imem_array.sv
// Instruction storage: synchronous write port, asynchronous read port. No reset, so
// contents survive a system reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write word index
//   wdata : write data
//   raddr : read word index
//   rdata : read data (combinational)
module boot_imem_array #(
  parameter int unsigned IDX_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**IDX_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/boot_imem.sv
// Writable instruction memory with streaming program loader. Holds the core in reset while a
// program is streamed in, then releases it and serves combinational fetches.
//   CLK   : clock, all state on rising edge
//   RESET : synchronous active-high reset (array contents are kept)
//   bus   : boot_imem_if slave modport (loader stream, core fetch, status)
// Build option BOOT_IMEM_CHECKSUM_EN adds a running-sum check of the stream (ld_csum/csum_ok).
module boot_imem
  import boot_imem_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(NOP_WORD_DEFAULT)
) (
  input logic       CLK,
  input logic       RESET,
  boot_imem_if.slave bus
);

  localparam int unsigned IdxWidth = ADDR_WIDTH - 2;
  localparam int unsigned CntWidth = ADDR_WIDTH - 1;
  localparam logic [CntWidth-1:0] LastIdx = CntWidth'(2**IdxWidth - 1);

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   count_q, count_d;
  logic                  core_run_q;
  logic                  ld_ready;
  logic                  accept;
  logic                  last_ok;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  unused_iaddr;

  assign ld_ready = (state_q == StLoad);
  // A restart in the same cycle as a valid word discards the word.
  assign accept   = bus.ld_valid & ld_ready & ~bus.load_start;

`ifdef BOOT_IMEM_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q;
  logic                  csum_ok_q;

  assign last_ok = (bus.ld_csum == sum_q + bus.ld_data);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sum_q     <= '0;
      csum_ok_q <= 1'b0;
    end else if (bus.load_start) begin
      sum_q     <= '0;
      csum_ok_q <= 1'b0;
    end else if (accept) begin
      sum_q <= sum_q + bus.ld_data;
      if (bus.ld_last) begin
        csum_ok_q <= last_ok;
      end
    end
  end

  assign bus.csum_ok = csum_ok_q;
`else
  assign last_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (bus.load_start) begin
      state_d = StLoad;
      count_d = '0;
    end else if (accept) begin
      count_d = count_q + 1'b1;
      if (bus.ld_last) begin
        state_d = last_ok ? StRun : StError;
      end else if (count_q == LastIdx) begin
        // Final slot written without ld_last: program does not fit.
        state_d = StError;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= StIdle;
      count_q    <= '0;
      core_run_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      core_run_q <= (state_d == StRun);
    end
  end

  boot_imem_array #(
    .IDX_WIDTH  (IdxWidth),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk   (CLK),
    .we    (accept),
    .waddr (count_q[IdxWidth-1:0]),
    .wdata (bus.ld_data),
    .raddr (bus.iaddr[ADDR_WIDTH-1:2]),
    .rdata (rd_data)
  );

  // Byte offset within the word is irrelevant for word fetches.
  assign unused_iaddr = ^bus.iaddr[1:0];

  assign bus.ld_ready     = ld_ready;
  assign bus.core_reset_n = core_run_q;
  assign bus.idata        = (state_q == StRun) ? rd_data : NOP_WORD;
  assign bus.load_done    = (state_q == StRun);
  assign bus.load_error   = (state_q == StError);
  assign bus.word_count   = count_q;

endmodule

// File: tb/tb_boot_imem.sv
module tb_boot_imem;

  logic CLK;
  logic RESET;

  boot_imem_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();
  boot_imem_if #(.ADDR_WIDTH(4),  .DATA_WIDTH(32)) sbus ();

  boot_imem #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) u_dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  boot_imem #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) u_small (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (sbus)
  );

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] small_model [4];
  int          n_pass;
  int          n_total;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One-cycle word on the large DUT; expectation recorded when the bench models acceptance.
  task automatic drive_word(input logic [31:0] d, input logic last, input bit accepted,
                            input int idx);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    bus.ld_last  = last;
    if (accepted) sb.push_back('{idx: idx, data: d});
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic drive_small(input logic [31:0] d, input logic last, input bit accepted,
                             input int idx);
    sbus.ld_valid = 1'b1;
    sbus.ld_data  = d;
    sbus.ld_last  = last;
    if (accepted) small_model[idx] = d;
    tick();
    sbus.ld_valid = 1'b0;
    sbus.ld_last  = 1'b0;
  endtask

  task automatic pulse_start();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick();
    tick();
    n_total++;
    if (bus.core_reset_n !== 1'b0) $display("FAIL reset_core_reset_n got %b want 0", bus.core_reset_n);
    else n_pass++;
    n_total++;
    if (bus.ld_ready !== 1'b0) $display("FAIL reset_ld_ready got %b want 0", bus.ld_ready);
    else n_pass++;
    n_total++;
    if (bus.idata !== NOP) $display("FAIL reset_idata got %h want %h", bus.idata, NOP);
    else n_pass++;
    n_total++;
    if (bus.word_count !== 9'd0) $display("FAIL reset_word_count got %0d want 0", bus.word_count);
    else n_pass++;
    n_total++;
    if ({bus.load_done, bus.load_error} !== 2'b00)
      $display("FAIL reset_status got %b want 00", {bus.load_done, bus.load_error});
    else n_pass++;
    RESET = 1'b0;
    tick();
  endtask

  task automatic drain_sb(input string tag);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      bus.iaddr = 10'(e.idx * 4 + int'($urandom_range(0, 3)));
      #1;
      n_total++;
      if (bus.idata !== e.data)
        $display("FAIL %s_read idx %0d got %h want %h", tag, e.idx, bus.idata, e.data);
      else n_pass++;
    end
  endtask

  task automatic test_load();
    logic [31:0] prog [4];
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h00A0_0113;
    prog[2] = 32'h0020_81B3;
    prog[3] = 32'h0000_006F;
    pulse_start();
    n_total++;
    if (bus.ld_ready !== 1'b1 || bus.idata !== NOP)
      $display("FAIL load_enter got ready=%b idata=%h want ready=1 idata=%h",
               bus.ld_ready, bus.idata, NOP);
    else n_pass++;
    for (int i = 0; i < 3; i++) drive_word(prog[i], 1'b0, 1'b1, i);
    n_total++;
    if (bus.core_reset_n !== 1'b0 || bus.load_done !== 1'b0)
      $display("FAIL load_hold got crn=%b done=%b want 0 0", bus.core_reset_n, bus.load_done);
    else n_pass++;
    drive_word(prog[3], 1'b1, 1'b1, 3);
    n_total++;
    if (bus.load_done !== 1'b1 || bus.core_reset_n !== 1'b1 || bus.word_count !== 9'd4)
      $display("FAIL load_run got done=%b crn=%b wc=%0d want 1 1 4",
               bus.load_done, bus.core_reset_n, bus.word_count);
    else n_pass++;
    bus.iaddr = 10'd8;
    #1;
    n_total++;
    if (bus.idata !== 32'h0020_81B3) $display("FAIL load_iaddr8 got %h want 002081b3", bus.idata);
    else n_pass++;
    drain_sb("load");
  endtask

  task automatic test_gapped();
    int k;
    k = 0;
    pulse_start();
    for (int c = 0; c < 6; c++) begin
      if (c % 2 == 0) begin
        drive_word(32'hA000_0000 + 32'(k), (k == 2) ? 1'b1 : 1'b0, 1'b1, k);
        k++;
      end else begin
        // Idle cycle with junk payload and ld_last set must be ignored.
        bus.ld_data = 32'hDEAD_BEEF;
        bus.ld_last = 1'b1;
        if (c != 5) begin
          tick();
        end
        bus.ld_last = 1'b0;
      end
    end
    n_total++;
    if (bus.load_done !== 1'b1 || bus.word_count !== 9'd3)
      $display("FAIL gapped_run got done=%b wc=%0d want 1 3", bus.load_done, bus.word_count);
    else n_pass++;
    drain_sb("gapped");
    bus.iaddr = 10'd12;
    #1;
    n_total++;
    if (bus.idata !== 32'h0000_006F) $display("FAIL gapped_keep got %h want 0000006f", bus.idata);
    else n_pass++;
  endtask

  task automatic test_overflow();
    sbus.load_start = 1'b1;
    tick();
    sbus.load_start = 1'b0;
    for (int i = 0; i < 4; i++) drive_small(32'hB000_0000 + 32'(i), 1'b0, 1'b1, i);
    n_total++;
    if (sbus.load_error !== 1'b1 || sbus.ld_ready !== 1'b0 || sbus.core_reset_n !== 1'b0)
      $display("FAIL ovf_error got err=%b ready=%b crn=%b want 1 0 0",
               sbus.load_error, sbus.ld_ready, sbus.core_reset_n);
    else n_pass++;
    drive_small(32'hB000_0004, 1'b0, 1'b0, 0);
    n_total++;
    if (sbus.word_count !== 3'd4 || sbus.load_error !== 1'b1 || sbus.idata !== NOP)
      $display("FAIL ovf_drop got wc=%0d err=%b idata=%h want 4 1 %h",
               sbus.word_count, sbus.load_error, sbus.idata, NOP);
    else n_pass++;
    // Reload, with a restart colliding with a valid word.
    sbus.load_start = 1'b1;
    tick();
    sbus.load_start = 1'b0;
    drive_small(32'hC000_0000, 1'b0, 1'b1, 0);
    sbus.load_start = 1'b1;
    drive_small(32'hC000_0001, 1'b0, 1'b0, 1);
    sbus.load_start = 1'b0;
    n_total++;
    if (sbus.word_count !== 3'd0 || sbus.ld_ready !== 1'b1)
      $display("FAIL restart_wins got wc=%0d ready=%b want 0 1", sbus.word_count, sbus.ld_ready);
    else n_pass++;
    drive_small(32'hC000_0002, 1'b1, 1'b1, 0);
    n_total++;
    if (sbus.load_done !== 1'b1 || sbus.word_count !== 3'd1)
      $display("FAIL small_run got done=%b wc=%0d want 1 1", sbus.load_done, sbus.word_count);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      sbus.iaddr = 4'(i * 4);
      #1;
      n_total++;
      if (sbus.idata !== small_model[i])
        $display("FAIL small_read idx %0d got %h want %h", i, sbus.idata, small_model[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    drive_word(32'hE000_0000, 1'b0, 1'b0, 0);
    drive_word(32'hE000_0001, 1'b0, 1'b0, 1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    n_total++;
    if (bus.ld_ready !== 1'b0 || bus.core_reset_n !== 1'b0 || bus.word_count !== 9'd0 ||
        bus.load_done !== 1'b0)
      $display("FAIL midreset got ready=%b crn=%b wc=%0d done=%b want 0 0 0 0",
               bus.ld_ready, bus.core_reset_n, bus.word_count, bus.load_done);
    else n_pass++;
    pulse_start();
    drive_word(32'h1111_1111, 1'b0, 1'b1, 0);
    drive_word(32'h2222_2222, 1'b0, 1'b1, 1);
    drive_word(32'h3333_3333, 1'b1, 1'b1, 2);
    n_total++;
    if (bus.load_done !== 1'b1 || bus.core_reset_n !== 1'b1)
      $display("FAIL midreset_run got done=%b crn=%b want 1 1", bus.load_done, bus.core_reset_n);
    else n_pass++;
    drain_sb("midreset");
  endtask

`ifdef BOOT_IMEM_CHECKSUM_EN
  task automatic test_checksum();
    for (int pass = 0; pass < 2; pass++) begin
      bus.ld_csum = (pass == 0) ? 32'd6 : 32'd7;
      pulse_start();
      drive_word(32'd1, 1'b0, 1'b0, 0);
      drive_word(32'd2, 1'b0, 1'b0, 1);
      drive_word(32'd3, 1'b1, 1'b0, 2);
      n_total++;
      if (pass == 0 && (bus.load_done !== 1'b1 || bus.csum_ok !== 1'b1))
        $display("FAIL csum_match got done=%b ok=%b want 1 1", bus.load_done, bus.csum_ok);
      else if (pass == 1 && (bus.load_error !== 1'b1 || bus.csum_ok !== 1'b0))
        $display("FAIL csum_mismatch got err=%b ok=%b want 1 0", bus.load_error, bus.csum_ok);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    n_pass          = 0;
    n_total         = 0;
    RESET           = 1'b1;
    bus.load_start  = 1'b0;
    bus.ld_valid    = 1'b0;
    bus.ld_data     = '0;
    bus.ld_last     = 1'b0;
    bus.iaddr       = '0;
    sbus.load_start = 1'b0;
    sbus.ld_valid   = 1'b0;
    sbus.ld_data    = '0;
    sbus.ld_last    = 1'b0;
    sbus.iaddr      = '0;
`ifdef BOOT_IMEM_CHECKSUM_EN
    bus.ld_csum     = '0;
    sbus.ld_csum    = '0;
`endif
    test_reset();
    test_load();
    test_gapped();
    test_overflow();
    test_reset_mid_load();
`ifdef BOOT_IMEM_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
